muxn_stream: RTL and testbench
==============================

Name: muxn_stream

Overview:
- Parametrised successor to the team's 2:1 8-bit mux: an N-input, WIDTH-bit registered stream multiplexer with per-channel valid/ready handshakes.
- Two select modes:
  - fixed mode: an external select chooses the source.
  - round-robin mode: the block arbitrates fairly among the valid inputs.
- One output register stage.
- Sits between multiple producers (e.g. datapath lanes) and a single downstream consumer.

Parameters:
- WIDTH, 8, data width in bits of each channel and of the output.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), select/index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- rr  input  1  mode: 0 = fixed select via s, 1 = round-robin.
- s  input  SELW  fixed-mode channel select.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered output data.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts a beat.

Behaviour:
- Reset: on a clk edge with reset_n=0:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - Any held beat is discarded.
  - in_ready is forced to all-zero while reset_n=0.
- load_en = !out_valid || out_ready (output register empty, or being drained this cycle).
- Grant (combinational):
  - rr=0: grant = s if s < N and in_valid[s]=1; otherwise no grant.
  - s >= N (non-power-of-2 N) always yields no grant.
  - rr=1: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., wrapping mod N. No grant if in_valid = 0.
- in_ready[i] = load_en && (grant == i). At most one bit is set. in_ready never depends on in_data.
- Transfer on channel i when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel i data.
  - out_sel <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod N. ptr updates in both modes.
- Drain without refill: if load_en and there is no grant, and out_ready=1, then out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid=1 && out_ready=0 means out_data and out_sel are held stable, and all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready is held high (simultaneous drain and refill in the same cycle).
- Wrap-around: a grant to channel N-1 sets ptr=0.
- Mode or select changes take effect combinationally for the next grant. A beat already in the output register is unaffected.
- Producers may deassert in_valid without a transfer; the block must not latch data from a channel whose in_valid=0.
- No combinational path from in_data to out_data.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000. After release, rr=1, channel 0 is granted first.
- Fixed mode (WIDTH=8, N=4): rr=0, out_ready=1, channel data 8'hA0..8'hA3, all valid. Sweep s=0..3 -> one cycle later out_data = 8'hA0, A1, A2, A3 and out_sel = 0, 1, 2, 3. in_ready = one-hot of s.
- Fixed mode with an invalid source: s=2, in_valid=4'b1011 -> no transfer; out_valid falls to 0 after draining.
- Round-robin fairness: rr=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Round-robin skip and wrap: in_valid=4'b1001, ptr=1 -> grant 3; next grant 0; then 3.
- Backpressure: rr=1, in_valid=4'b1111, out_ready=0 for 3 cycles after the first beat (8'hA0) -> out_data stays 8'hA0, in_ready=0, no channel is lost. After out_ready=1, the sequence resumes at channel 1.
- Reset mid-stall: out_valid=1 holding 8'hA2; assert reset_n=0 for 1 cycle -> out_valid=0, out_data=0, ptr=0.

Source files
------------

// File: rtl/muxn_stream.sv
// muxn_stream: N-input registered stream mux with fixed-select and round-robin modes
module muxn_stream #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rr,
  input  logic [SELW-1:0]      s,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_hit;
  logic            fix_hit;
  logic [SELW-1:0] gnt;
  logic            gnt_hit;
  logic            load_en;
  logic            take;
  assign load_en = !out_valid || out_ready;
  assign fix_hit = (int'(s) < N) && in_valid[s];
  // round-robin: first valid channel scanning upward from ptr with wrap; descending loop lets the nearest win
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[(int'(ptr) + k) % N]) begin
        rr_hit = 1'b1;
        rr_idx = SELW'((int'(ptr) + k) % N);
      end
    end
  end
  assign gnt_hit = rr ? rr_hit : fix_hit;
  assign gnt = rr ? rr_idx : s;
  assign take = reset_n && load_en && gnt_hit;
  assign in_ready = take ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
  // output register: load on transfer, empty on drain without refill, hold while stalled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(gnt)*WIDTH +: WIDTH];
      out_sel <= gnt;
      ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_muxn_stream.sv
// tb_muxn_stream: directed checks of muxn_stream with N=4, WIDTH=8
module tb_muxn_stream;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       rr;
  logic [1:0] s;
  logic [3:0] in_valid;
  logic [31:0] in_data;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;
  int checks = 0;
  int errors = 0;
  muxn_stream #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .reset_n(reset_n), .rr(rr), .s(s), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [1:0] sel);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
    chk({tag, "_data"}, 32'(out_data), 32'hA0 + 32'(sel));
  endtask
  initial begin
    reset_n = 1'b0;
    rr = 1'b1;
    s = 2'd0;
    in_valid = 4'hF;
    in_data = 32'hA3A2A1A0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_sel", 32'(out_sel), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset_n = 1'b1;
    #1 chk("rel_rr_ready", 32'(in_ready), 4'b0001);
    rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1 chk("fix_ready", 32'(in_ready), 32'(1) << i);
      beat("fix", 2'(i));
    end
    s = 2'd2;
    in_valid = 4'b1011;
    #1 chk("inv_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("inv_valid", 32'(out_valid), 0);
    chk("inv_hold_data", 32'(out_data), 32'hA3);
    chk("inv_hold_sel", 32'(out_sel), 3);
    rr = 1'b1;
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) beat("rr", 2'(k % 4));
    in_valid = 4'b0001;
    beat("pre_skip", 2'd0);
    in_valid = 4'b1001;
    beat("skip0", 2'd3);
    beat("skip1", 2'd0);
    beat("skip2", 2'd3);
    in_valid = 4'hF;
    beat("bp_first", 2'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(in_ready), 0);
      beat("bp_hold", 2'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_resume_ready", 32'(in_ready), 4'b0010);
    beat("bp_resume1", 2'd1);
    beat("bp_resume2", 2'd2);
    out_ready = 1'b0;
    beat("stall", 2'd2);
    reset_n = 1'b0;
    #1 chk("mid_rst_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_sel", 32'(out_sel), 0);
    reset_n = 1'b1;
    #1 chk("mid_rst_ptr", 32'(in_ready), 4'b0001);
    in_valid = 4'b0000;
    out_ready = 1'b1;
    #1 chk("idle_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
